// File: rtl/ae_luma_stats.sv
// Per-frame luma statistics for auto-exposure: RGB888 -> luma, windowed sum,
// and a serial divide at each frame boundary that yields the mean brightness.
module ae_luma_stats #(
  parameter int H_START   = 0,
  parameter int H_END     = 1280,
  parameter int V_START   = 0,
  parameter int V_END     = 720,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       de,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] avg_brightness,
  output logic       frame_done,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic        vs_d_q, vs_d_d;
  logic        de_q, de_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [7:0]  luma_q, luma_d;
  logic        luma_vld_q, luma_vld_d;
  logic        win_q, win_d;
  logic [31:0] acc_q, acc_d;
  logic [23:0] cnt_q, cnt_d;
  logic [4:0]  iter_q, iter_d;
  logic [31:0] dq_q, dq_d;
  logic [23:0] rem_q, rem_d;
  logic [23:0] dvs_q, dvs_d;
  logic [7:0]  avg_q, avg_d;
  logic        overrun_q, overrun_d;

  logic        frame_edge;
  logic [15:0] luma_sum;
  logic signed [31:0] x_s, y_s;
  logic        in_win;
  logic [32:0] acc_sum;
  logic [24:0] rem_shift;
  logic        rem_ge;
  logic [23:0] rem_next;
  logic [31:0] dq_next;
  logic [7:0]  quot_sat;

  assign frame_edge = VSYNC_POL ? (vsync & ~vs_d_q) : (~vsync & vs_d_q);

  // Weights sum to 256, so the rounded result never exceeds 16 bits.
  assign luma_sum = 16'd77 * {8'd0, r} + 16'd150 * {8'd0, g}
                  + 16'd29 * {8'd0, b} + 16'd128;

  assign x_s    = {16'd0, x_q};
  assign y_s    = {16'd0, y_q};
  assign in_win = (x_s >= H_START) && (x_s < H_END) &&
                  (y_s >= V_START) && (y_s < V_END);

  always_comb begin
    vs_d_d     = vsync;
    de_d       = de;
    luma_d     = 8'(luma_sum >> 8);
    luma_vld_d = de;
    win_d      = in_win;

    x_d = x_q;
    y_d = y_q;
    if (frame_edge) begin
      x_d = '0;
      y_d = '0;
    end else if (de) begin
      if (x_q != '1) x_d = x_q + 16'd1;
    end else if (de_q) begin
      x_d = '0;
      if (y_q != '1) y_d = y_q + 16'd1;
    end
  end

  assign acc_sum = {1'b0, acc_q} + {25'd0, luma_q};

  // The boundary cycle clears the sums, so a pixel landing there is dropped.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (frame_edge) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (luma_vld_q && win_q) begin
      acc_d = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
      if (cnt_q != '1) cnt_d = cnt_q + 24'd1;
    end
  end

  assign rem_shift = {rem_q, dq_q[31]};
  assign rem_ge    = rem_shift >= {1'b0, dvs_q};
  assign rem_next  = rem_ge ? 24'(rem_shift - {1'b0, dvs_q}) : rem_shift[23:0];
  assign dq_next   = {dq_q[30:0], rem_ge};
  assign quot_sat  = (dq_next[31:8] != 24'd0) ? 8'hFF : dq_next[7:0];

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    dq_d      = dq_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    avg_d     = avg_q;
    overrun_d = frame_edge && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (frame_edge) begin
          state_d = DIV;
          iter_d  = '0;
          dq_d    = acc_q;
          rem_d   = '0;
          dvs_d   = cnt_q;
        end
      end
      DIV: begin
        dq_d   = dq_next;
        rem_d  = rem_next;
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd31) begin
          state_d = DONE;
          avg_d   = (dvs_q == 24'd0) ? 8'd0 : quot_sat;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vs_d_q     <= 1'b0;
      de_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      luma_q     <= '0;
      luma_vld_q <= 1'b0;
      win_q      <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      iter_q     <= '0;
      dq_q       <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      avg_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_d_q     <= vs_d_d;
      de_q       <= de_d;
      x_q        <= x_d;
      y_q        <= y_d;
      luma_q     <= luma_d;
      luma_vld_q <= luma_vld_d;
      win_q      <= win_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      iter_q     <= iter_d;
      dq_q       <= dq_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      avg_q      <= avg_d;
      overrun_q  <= overrun_d;
    end
  end

  assign avg_brightness = avg_q;
  assign frame_done     = (state_q == DONE);
  assign busy           = (state_q != IDLE);
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_ae_luma_stats.sv
// Directed bench for ae_luma_stats: three windows driven by one 6x6 video stream,
// checking averages and the 33-cycle edge-to-frame_done timing.
module tb_ae_luma_stats;

  logic       clk = 1'b0;
  logic       rst, vsync, de;
  logic [7:0] r, g, b;

  logic [7:0] avg_a, avg_b, avg_c;
  logic       fd_a, fd_b, fd_c;
  logic       busy_a, busy_b, busy_c;
  logic       ovr_a, ovr_b, ovr_c;

  ae_luma_stats #(.H_START(0), .H_END(4), .V_START(0), .V_END(4), .VSYNC_POL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .vsync(vsync), .de(de), .r(r), .g(g), .b(b),
    .avg_brightness(avg_a), .frame_done(fd_a), .busy(busy_a), .overrun(ovr_a));

  ae_luma_stats #(.H_START(1), .H_END(3), .V_START(1), .V_END(3), .VSYNC_POL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .vsync(vsync), .de(de), .r(r), .g(g), .b(b),
    .avg_brightness(avg_b), .frame_done(fd_b), .busy(busy_b), .overrun(ovr_b));

  ae_luma_stats #(.H_START(0), .H_END(4), .V_START(10), .V_END(720), .VSYNC_POL(1'b1)) dut_c (
    .clk(clk), .rst(rst), .vsync(vsync), .de(de), .r(r), .g(g), .b(b),
    .avg_brightness(avg_c), .frame_done(fd_c), .busy(busy_c), .overrun(ovr_c));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r, g, b;
    bit         center;
    int         exp_a, exp_b, exp_c;
    string      name;
  } vec_t;

  vec_t vecs[6];

  int n_checks = 0;
  int n_pass   = 0;

  logic       fd_h[0:63], fd_c_h[0:63], busy_h[0:63], ovr_h[0:63];
  logic [7:0] avg_a_h[0:63], avg_b_h[0:63], avg_c_h[0:63];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // One 6x6 frame: 6 active pixels per line, 2 blanking cycles, 4 idle cycles at the end.
  task automatic applyStimulus(input logic [7:0] rv, input logic [7:0] gv,
                               input logic [7:0] bv, input bit center);
    for (int line = 0; line < 6; line++) begin
      for (int px = 0; px < 6; px++) begin
        @(negedge clk);
        de = 1'b1;
        if (center && !(px >= 1 && px <= 2 && line >= 1 && line <= 2)) begin
          r = 8'd0; g = 8'd0; b = 8'd0;
        end else begin
          r = rv; g = gv; b = bv;
        end
      end
      repeat (2) begin
        @(negedge clk);
        de = 1'b0; r = 8'd0; g = 8'd0; b = 8'd0;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  // Raises vsync (cycle E = index 0) and records outputs for cycles E+1..E+len.
  task automatic observeEdge(input int second_at, input int rst_at, input int len);
    @(negedge clk);
    vsync = 1'b1;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      fd_h[k]    = fd_a;
      fd_c_h[k]  = fd_c;
      busy_h[k]  = busy_a;
      ovr_h[k]   = ovr_a;
      avg_a_h[k] = avg_a;
      avg_b_h[k] = avg_b;
      avg_c_h[k] = avg_c;
      if (k == 2) vsync = 1'b0;
      if (k == second_at) vsync = 1'b1;
      if (k == second_at + 2) vsync = 1'b0;
      if (k == rst_at) rst = 1'b1;
      if (k == rst_at + 1) rst = 1'b0;
    end
    vsync = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic scanPulses(input int len, output int fd_first, output int fd_cnt,
                            output int ovr_first, output int ovr_cnt);
    fd_first = -1; fd_cnt = 0; ovr_first = -1; ovr_cnt = 0;
    for (int k = 1; k <= len; k++) begin
      if (fd_h[k]) begin
        if (fd_first < 0) fd_first = k;
        fd_cnt++;
      end
      if (ovr_h[k]) begin
        if (ovr_first < 0) ovr_first = k;
        ovr_cnt++;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fd_first, fd_cnt, ovr_first, ovr_cnt;
    int prev;

    vecs[0] = '{8'd100, 8'd100, 8'd100, 1'b0, 100, 100, 0, "gray100"};
    vecs[1] = '{8'd255, 8'd0,   8'd0,   1'b0, 77,  77,  0, "red"};
    vecs[2] = '{8'd0,   8'd255, 8'd0,   1'b0, 149, 149, 0, "green"};
    vecs[3] = '{8'd255, 8'd255, 8'd255, 1'b0, 255, 255, 0, "white"};
    vecs[4] = '{8'd200, 8'd200, 8'd200, 1'b1, 50,  200, 0, "center200"};
    vecs[5] = '{8'd0,   8'd0,   8'd255, 1'b0, 29,  29,  0, "blue"};

    rst = 1'b1; vsync = 1'b0; de = 1'b0; r = 8'd0; g = 8'd0; b = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset avg", avg_a, 0);
    checkOutput("reset frame_done", fd_a, 0);
    checkOutput("reset busy", busy_a, 0);
    checkOutput("reset overrun", ovr_a, 0);
    rst = 1'b0;
    @(negedge clk);

    prev = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].center);
      observeEdge(-1, -1, 40);
      scanPulses(40, fd_first, fd_cnt, ovr_first, ovr_cnt);
      checkOutput({vecs[i].name, " frame_done cycle"}, fd_first, 33);
      checkOutput({vecs[i].name, " frame_done count"}, fd_cnt, 1);
      checkOutput({vecs[i].name, " overrun count"}, ovr_cnt, 0);
      checkOutput({vecs[i].name, " avg held before done"}, avg_a_h[32], prev);
      checkOutput({vecs[i].name, " avg window A"}, avg_a_h[33], vecs[i].exp_a);
      checkOutput({vecs[i].name, " avg window B"}, avg_b_h[33], vecs[i].exp_b);
      checkOutput({vecs[i].name, " avg empty window"}, avg_c_h[33], vecs[i].exp_c);
      checkOutput({vecs[i].name, " empty window frame_done"}, fd_c_h[33], 1);
      checkOutput({vecs[i].name, " busy at E+1"}, busy_h[1], 1);
      checkOutput({vecs[i].name, " busy at E+34"}, busy_h[34], 0);
      prev = vecs[i].exp_a;
    end

    // Second edge 10 cycles in: snapshot dropped, first result still delivered.
    applyStimulus(8'd100, 8'd100, 8'd100, 1'b0);
    observeEdge(10, -1, 50);
    scanPulses(50, fd_first, fd_cnt, ovr_first, ovr_cnt);
    checkOutput("early edge overrun cycle", ovr_first, 11);
    checkOutput("early edge overrun count", ovr_cnt, 1);
    checkOutput("early edge frame_done cycle", fd_first, 33);
    checkOutput("early edge frame_done count", fd_cnt, 1);
    checkOutput("early edge avg", avg_a_h[33], 100);
    checkOutput("early edge avg held", avg_a_h[50], 100);

    // Edge landing in the DONE cycle is also dropped.
    applyStimulus(8'd255, 8'd255, 8'd255, 1'b0);
    observeEdge(33, -1, 45);
    scanPulses(45, fd_first, fd_cnt, ovr_first, ovr_cnt);
    checkOutput("done edge frame_done cycle", fd_first, 33);
    checkOutput("done edge frame_done count", fd_cnt, 1);
    checkOutput("done edge overrun cycle", ovr_first, 34);
    checkOutput("done edge avg", avg_a_h[33], 255);
    checkOutput("done edge busy after", busy_h[34], 0);

    // Reset in the middle of a division.
    applyStimulus(8'd0, 8'd255, 8'd0, 1'b0);
    observeEdge(-1, 15, 45);
    scanPulses(45, fd_first, fd_cnt, ovr_first, ovr_cnt);
    checkOutput("mid reset busy before", busy_h[15], 1);
    checkOutput("mid reset busy after", busy_h[16], 0);
    checkOutput("mid reset avg after", avg_a_h[16], 0);
    checkOutput("mid reset frame_done count", fd_cnt, 0);
    checkOutput("mid reset avg end", avg_a_h[45], 0);

    applyStimulus(8'd100, 8'd100, 8'd100, 1'b0);
    observeEdge(-1, -1, 40);
    scanPulses(40, fd_first, fd_cnt, ovr_first, ovr_cnt);
    checkOutput("post reset frame_done cycle", fd_first, 33);
    checkOutput("post reset avg", avg_a_h[33], 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
